ads868x_scan_ctrl: RTL

ADS868X_SCAN_CTRL -- requirements
Module: ads868x_scan_ctrl

---
 rtl/ads868x_scan_ctrl_if.sv | 19 +
 rtl/ads868x_scan_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ads868x_scan_ctrl_if.sv
// AXI-Stream sample bus between the ADS868x scan controller and its consumer.
// master drives the sample, slave returns m_tready.
interface ads868x_scan_ctrl_if;
    logic [15:0] m_tdata;
    logic [2:0]  m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;

    modport master (
        output m_tdata, m_tuser, m_tlast, m_tvalid,
        input  m_tready
    );

    modport slave (
        input  m_tdata, m_tuser, m_tlast, m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/ads868x_scan_ctrl.sv
// ADS868x mux scan controller: settle, convert, 32-clock SPI read, AXI-S out.
// Optional ADS868X_PTP_TRIG_EN: scans start on a synchronized trig rising edge.
module ads868x_scan_ctrl #(
    parameter int CLK_DIV       = 4,
    parameter int SETTLE_CYCLES = 200,
    parameter int CONV_CYCLES   = 100
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       enable,
    input  logic [7:0] ch_mask,
    input  logic       trig,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [2:0] ch_sel,
    output logic       busy,
    ads868x_scan_ctrl_if.master m_axis
);

    localparam int CMAX = (SETTLE_CYCLES > CONV_CYCLES) ?
                          SETTLE_CYCLES : CONV_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST   = CW'(CONV_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, CONV, XFER, OUT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div_cnt;
    logic [6:0]    edge_cnt;
    logic [15:0]   shift;
    logic [7:0]    mask_q;
    logic [2:0]    ch;
    logic [2:0]    first_ch;
    logic [2:0]    nxt_ch;
    logic          has_nxt;
    logic          start;
    logic          restart;
    logic          sclk_tick;
    logic          xfer_done;
    logic          load_scan;
    logic          step_ch;

`ifdef ADS868X_PTP_TRIG_EN
    logic [2:0] trig_sync;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) trig_sync <= '0;
        else          trig_sync <= {trig_sync[1:0], trig};
    end

    assign start   = enable && trig_sync[1] && !trig_sync[2];
    assign restart = 1'b0;
`else
    logic unused_trig;

    assign unused_trig = trig;
    assign start       = enable;
    assign restart     = enable && (|ch_mask);
`endif

    always_comb begin
        first_ch = '0;
        for (int i = 7; i >= 0; i--)
            if (ch_mask[i]) first_ch = 3'(i);
    end

    // Lowest enabled channel above the current one in the latched mask.
    always_comb begin
        has_nxt = 1'b0;
        nxt_ch  = '0;
        for (int i = 7; i >= 0; i--)
            if (mask_q[i] && i > int'(ch)) begin
                has_nxt = 1'b1;
                nxt_ch  = 3'(i);
            end
    end

    assign sclk_tick = (div_cnt == DIV_LAST);
    assign xfer_done = (state == XFER) && sclk_tick && (edge_cnt == 7'd64);
    assign load_scan = (state_nxt == SETTLE) &&
                       ((state == IDLE) || m_axis.m_tlast);
    assign step_ch   = (state == OUT) && (state_nxt == SETTLE) &&
                       !m_axis.m_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (start && (|ch_mask)) state_nxt = SETTLE;
            SETTLE:
                if (cnt == SETTLE_LAST) state_nxt = CONV;
            CONV:
                if (cnt == CONV_LAST) state_nxt = XFER;
            XFER:
                if (xfer_done) state_nxt = OUT;
            OUT:
                if (m_axis.m_tready) begin
                    if (!m_axis.m_tlast || restart) state_nxt = SETTLE;
                    else                            state_nxt = IDLE;
                end
            default:
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spi_cs_n        = (state != XFER);
        spi_mosi        = 1'b0;
        busy            = (state != IDLE);
        m_axis.m_tvalid = (state == OUT);
        ch_sel          = ch;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt            <= '0;
            div_cnt        <= '0;
            edge_cnt       <= '0;
            spi_sclk       <= 1'b0;
            shift          <= '0;
            mask_q         <= '0;
            ch             <= '0;
            m_axis.m_tdata <= '0;
            m_axis.m_tuser <= '0;
            m_axis.m_tlast <= 1'b0;
        end else begin
            if (state_nxt != state)
                cnt <= '0;
            else if (state == SETTLE || state == CONV)
                cnt <= cnt + 1'b1;

            // 64 SCLK edges, each CLK_DIV cycles apart, plus a trailing CS hold.
            if (state != XFER) begin
                div_cnt  <= '0;
                edge_cnt <= '0;
                spi_sclk <= 1'b0;
            end else if (sclk_tick) begin
                div_cnt <= '0;
                if (edge_cnt != 7'd64) begin
                    edge_cnt <= edge_cnt + 1'b1;
                    spi_sclk <= ~spi_sclk;
                    if (!edge_cnt[0] && edge_cnt < 7'd32)
                        shift <= {shift[14:0], spi_miso};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (load_scan) begin
                mask_q <= ch_mask;
                ch     <= first_ch;
            end else if (step_ch) begin
                ch <= nxt_ch;
            end

            if (xfer_done) begin
                m_axis.m_tdata <= shift;
                m_axis.m_tuser <= ch;
                m_axis.m_tlast <= !has_nxt || !enable;
            end
        end
    end

endmodule
